// File: rtl/alu_op_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of the shared ALU core.
// Issues one operation at a time, waits for done or timeout, returns the result and keeps status counters.
module alu_op_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,

    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_c,
    output logic        resp_err,
    output logic        resp_timeout,

    output logic        alu_start,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic        alu_done,
    input  logic [31:0] alu_c,
    input  logic        alu_err,

    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err,
    output logic [15:0] cnt_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic        owner;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [2:0]  op_r;
    logic [15:0] wait_cnt;

    logic [1:0]  grant;
    logic        fire;
    logic        resp_hs;

    // On a tie the client that did not complete last wins; last_grant resets to 1 so client 0 wins first.
    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE) ? grant : '0;
        fire       = |req_ready;
        alu_start  = (state == S_ISSUE);
        resp_valid = '0;
        if (state == S_RESP) begin
            resp_valid = owner ? 2'b10 : 2'b01;
        end
        resp_hs    = (state == S_RESP) && (owner ? resp_ready[1] : resp_ready[0]);
    end

    assign alu_a  = a_r;
    assign alu_b  = b_r;
    assign alu_op = op_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= '0;
            wait_cnt     <= '0;
            resp_c       <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        owner <= grant[1];
                        if (grant[1]) begin
                            a_r  <= req1_a;
                            b_r  <= req1_b;
                            op_r <= req1_op;
                        end else begin
                            a_r  <= req0_a;
                            b_r  <= req0_b;
                            op_r <= req0_op;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // done takes priority over a coincident terminal count
                    if (alu_done) begin
                        resp_c       <= alu_c;
                        resp_err     <= alu_err;
                        resp_timeout <= 1'b0;
                        state        <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        resp_c       <= '0;
                        resp_err     <= 1'b0;
                        resp_timeout <= 1'b1;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_hs) begin
                        last_grant <= owner;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ok      <= '0;
            cnt_err     <= '0;
            cnt_timeout <= '0;
        end else if (resp_hs) begin
            if (resp_timeout) begin
                if (cnt_timeout != '1) cnt_timeout <= cnt_timeout + 16'd1;
            end else if (resp_err) begin
                if (cnt_err != '1) cnt_err <= cnt_err + 16'd1;
            end else begin
                if (cnt_ok != '1) cnt_ok <= cnt_ok + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter with TIMEOUT=8 and a simple responding ALU model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_alu_op_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_c;
    logic        resp_err, resp_timeout;
    logic        alu_start;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_done;
    logic [31:0] alu_c;
    logic        alu_err;
    logic [15:0] cnt_ok, cnt_err, cnt_timeout;

    logic alu_en, err_mode, inject, seen_start;
    int   n_cmp, n_fail;

    localparam logic [31:0] ERR_C = {1'b0, 6'b100100, 25'd0};

    alu_op_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_c(resp_c), .resp_err(resp_err), .resp_timeout(resp_timeout),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_c(alu_c), .alu_err(alu_err),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err), .cnt_timeout(cnt_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: answers a start one cycle later with A+B (or an error word); inject forces a done now.
    initial begin
        alu_done = 1'b0; alu_c = '0; alu_err = 1'b0; seen_start = 1'b0;
        forever begin
            @(negedge clk);
            seen_start = alu_start & alu_en;
            @(posedge clk);
            #2;
            alu_done = seen_start | inject;
            if (seen_start | inject) begin
                alu_err = err_mode;
                alu_c   = err_mode ? ERR_C : alu_a + alu_b;
            end else begin
                alu_err = 1'b1;
                alu_c   = 32'hDEADBEEF;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) cyc();
        smp();
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_cmp++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        n_cmp++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL reset_alu_start: got %b want 0", alu_start); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_fail++; $display("FAIL reset_alu_operands: got %h %h %h want 0", alu_a, alu_b, alu_op); end
        n_cmp++; if ({resp_c, resp_err, resp_timeout} !== 34'd0) begin n_fail++; $display("FAIL reset_resp: got %h %b %b want 0", resp_c, resp_err, resp_timeout); end
        n_cmp++; if ({cnt_ok, cnt_err, cnt_timeout} !== 48'd0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d %0d want 0", cnt_ok, cnt_err, cnt_timeout); end
        cyc(); rst = 1'b0;
    endtask

    task automatic test_single;
        cyc(); req_valid = 2'b01; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b100;
        smp();
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
        cyc();
        smp();
        n_cmp++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL single_alu_start: got %b want 1", alu_start); end
        n_cmp++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b100) begin n_fail++; $display("FAIL single_alu_operands: got %0d %0d %b want 5 3 100", alu_a, alu_b, alu_op); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_in_issue: got %b want 00", req_ready); end
        cyc(); req_valid = 2'b00;
        smp();
        n_cmp++; if (alu_start !== 1'b0 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_wait_cycle: got start=%b rv=%b want 0 00", alu_start, resp_valid); end
        cyc(); resp_ready = 2'b01;
        smp();
        n_cmp++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b want 01", resp_valid); end
        n_cmp++; if (resp_c !== 32'd8 || resp_err !== 1'b0 || resp_timeout !== 1'b0) begin n_fail++; $display("FAIL single_resp_data: got %0h %b %b want 8 0 0", resp_c, resp_err, resp_timeout); end
        n_cmp++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL single_alu_a_stable: got %0d want 5", alu_a); end
        cyc(); resp_ready = 2'b00;
        smp();
        n_cmp++; if (resp_valid !== 2'b00 || cnt_ok !== 16'd1 || cnt_err !== 16'd0) begin n_fail++; $display("FAIL single_done: got rv=%b ok=%0d err=%0d want 00 1 0", resp_valid, cnt_ok, cnt_err); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] oh;
        do_reset();
        cyc();
        req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'd0;
        req1_a = 32'd20; req1_b = 32'd2; req1_op = 3'd1;
        req_valid = 2'b11; resp_ready = 2'b11;
        smp();
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            n_cmp++; if (req_ready !== oh) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, oh); end
            cyc(); smp();
            n_cmp++; if (alu_start !== 1'b1 || alu_op !== ((k % 2 == 1) ? 3'd1 : 3'd0) || req_ready !== 2'b00) begin n_fail++; $display("FAIL b2b_issue%0d: got start=%b op=%0d rr=%b", k, alu_start, alu_op, req_ready); end
            cyc(); smp();
            cyc(); smp();
            n_cmp++; if (resp_valid !== oh || resp_c !== ((k % 2 == 1) ? 32'd22 : 32'd11)) begin n_fail++; $display("FAIL b2b_resp%0d: got rv=%b c=%0d want %b %0d", k, resp_valid, resp_c, oh, (k % 2 == 1) ? 22 : 11); end
            cyc();
            if (k == 3) req_valid = 2'b00;
            smp();
        end
        n_cmp++; if (cnt_ok !== 16'd4 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_count: got ok=%0d rv=%b want 4 00", cnt_ok, resp_valid); end
    endtask

    task automatic test_error;
        cyc(); req_valid = 2'b10; req1_a = 32'd7; req1_b = 32'd9; err_mode = 1'b1;
        smp();
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL err_grant: got %b want 10", req_ready); end
        cyc(); req_valid = 2'b00; smp();
        cyc(); smp();
        cyc(); smp();
        n_cmp++; if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_timeout !== 1'b0) begin n_fail++; $display("FAIL err_resp: got rv=%b err=%b to=%b want 10 1 0", resp_valid, resp_err, resp_timeout); end
        n_cmp++; if (resp_c[30:25] !== 6'b100100) begin n_fail++; $display("FAIL err_flags: got %b want 100100", resp_c[30:25]); end
        cyc(); err_mode = 1'b0; smp();
        n_cmp++; if (cnt_err !== 16'd1 || cnt_ok !== 16'd4) begin n_fail++; $display("FAIL err_count: got err=%0d ok=%0d want 1 4", cnt_err, cnt_ok); end
    endtask

    task automatic test_timeout;
        alu_en = 1'b0; resp_ready = 2'b00;
        cyc(); req_valid = 2'b01; req0_a = 32'd1; req0_b = 32'd2;
        smp();
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL to_grant: got %b want 01", req_ready); end
        cyc(); req_valid = 2'b00; smp();
        repeat (8) begin cyc(); smp(); end
        n_cmp++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL to_early: got %b want 00 at fire+9", resp_valid); end
        cyc(); smp();
        n_cmp++; if (resp_valid !== 2'b01 || resp_timeout !== 1'b1 || resp_c !== 32'd0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL to_resp: got rv=%b to=%b c=%0h err=%b want 01 1 0 0", resp_valid, resp_timeout, resp_c, resp_err); end
        cyc(); smp();
        cyc(); smp();
        cyc(); inject = 1'b1; smp();
        n_cmp++; if (resp_valid !== 2'b01 || resp_c !== 32'd0 || resp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_late_done: got rv=%b c=%0h to=%b want 01 0 1", resp_valid, resp_c, resp_timeout); end
        cyc(); inject = 1'b0; resp_ready = 2'b01; smp();
        cyc(); resp_ready = 2'b00; smp();
        n_cmp++; if (cnt_timeout !== 16'd1 || cnt_ok !== 16'd4 || cnt_err !== 16'd1 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL to_count: got to=%0d ok=%0d err=%0d rv=%b want 1 4 1 00", cnt_timeout, cnt_ok, cnt_err, resp_valid); end
        cyc(); inject = 1'b1; smp();
        cyc(); inject = 1'b0; smp();
        n_cmp++; if (resp_valid !== 2'b00 || alu_start !== 1'b0 || cnt_ok !== 16'd4) begin n_fail++; $display("FAIL to_stray_done: got rv=%b start=%b ok=%0d want 00 0 4", resp_valid, alu_start, cnt_ok); end
        alu_en = 1'b1;
    endtask

    task automatic test_hold;
        resp_ready = 2'b01;
        cyc(); req_valid = 2'b10; req1_a = 32'd100; req1_b = 32'd23; req0_a = 32'd40; req0_b = 32'd2;
        smp();
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b want 10", req_ready); end
        cyc(); req_valid = 2'b01; smp();
        cyc(); smp();
        cyc(); smp();
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (resp_valid !== 2'b10 || resp_c !== 32'd123 || req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_cycle%0d: got rv=%b c=%0d rr=%b want 10 123 00", i, resp_valid, resp_c, req_ready); end
            cyc();
            if (i == 19) resp_ready = 2'b10;
            smp();
        end
        cyc(); resp_ready = 2'b00; smp();
        n_cmp++; if (req_ready !== 2'b01 || cnt_ok !== 16'd5) begin n_fail++; $display("FAIL hold_regrant: got rr=%b ok=%0d want 01 5", req_ready, cnt_ok); end
        cyc(); req_valid = 2'b00; smp();
        n_cmp++; if (alu_start !== 1'b1 || alu_a !== 32'd40) begin n_fail++; $display("FAIL hold_issue0: got start=%b a=%0d want 1 40", alu_start, alu_a); end
        cyc(); smp();
        cyc(); resp_ready = 2'b01; smp();
        n_cmp++; if (resp_valid !== 2'b01 || resp_c !== 32'd42) begin n_fail++; $display("FAIL hold_resp0: got rv=%b c=%0d want 01 42", resp_valid, resp_c); end
        cyc(); resp_ready = 2'b00; smp();
        n_cmp++; if (cnt_ok !== 16'd6) begin n_fail++; $display("FAIL hold_count: got %0d want 6", cnt_ok); end
    endtask

    task automatic test_reset_mid;
        alu_en = 1'b0;
        cyc(); req_valid = 2'b01; req0_a = 32'd2; req0_b = 32'd2; smp();
        cyc(); req_valid = 2'b00; smp();
        n_cmp++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: got %b want 1", alu_start); end
        cyc(); smp();
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0; alu_en = 1'b1; smp();
        n_cmp++; if (resp_valid !== 2'b00 || alu_start !== 1'b0 || alu_a !== 32'd0) begin n_fail++; $display("FAIL rmid_abort: got rv=%b start=%b a=%0d want 00 0 0", resp_valid, alu_start, alu_a); end
        n_cmp++; if ({cnt_ok, cnt_err, cnt_timeout} !== 48'd0) begin n_fail++; $display("FAIL rmid_counters: got %0d %0d %0d want 0 0 0", cnt_ok, cnt_err, cnt_timeout); end
        cyc(); smp();
        n_cmp++; if (resp_valid !== 2'b00 || alu_start !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet: got rv=%b start=%b want 00 0", resp_valid, alu_start); end
        cyc(); req_valid = 2'b01; req0_a = 32'd6; req0_b = 32'd7; smp();
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_grant: got %b want 01", req_ready); end
        cyc(); req_valid = 2'b00; smp();
        cyc(); smp();
        cyc(); resp_ready = 2'b01; smp();
        n_cmp++; if (resp_valid !== 2'b01 || resp_c !== 32'd13) begin n_fail++; $display("FAIL rmid_resp: got rv=%b c=%0d want 01 13", resp_valid, resp_c); end
        cyc(); resp_ready = 2'b00; smp();
        n_cmp++; if (cnt_ok !== 16'd1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", cnt_ok); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        alu_en = 1'b1; err_mode = 1'b0; inject = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_timeout();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
